// File: rtl/complex_divider.sv
// Sequential complex divider: z = x1*conj(x2) / |x2|^2 in signed Q-format.
// One multiply cycle, then a shared-denominator restoring divide, one quotient bit per cycle.
module complex_divider #(
  parameter int N = 16,
  parameter int Q = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] x1_real,
  input  logic [N-1:0] x1_imag,
  input  logic [N-1:0] x2_real,
  input  logic [N-1:0] x2_imag,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] z_real,
  output logic [N-1:0] z_imag
);

  localparam int W  = 2*N + Q;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST    = CW'(W - 1);
  localparam logic [W-1:0]  POS_LIM = W'((2**(N-1)) - 1);
  localparam logic [W-1:0]  NEG_LIM = W'(2**(N-1));

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  a_re, a_im, b_re, b_im;
  logic [2*N-1:0] den;
  logic          neg_re, neg_im;
  logic [2*N-1:0] rem_re, rem_im;
  logic [W-1:0]  dq_re, dq_im;
  logic [CW-1:0] cnt;

  // Multiply stage: operands sign-extended to 2N bits so every product is exact.
  logic signed [2*N-1:0] ar_x, ai_x, br_x, bi_x;
  logic signed [2*N-1:0] p_rr, p_ii, p_ir, p_ri, p_bb_r, p_bb_i;
  logic [2*N:0]   num_re, num_im;
  logic [2*N-1:0] abs_re, abs_im;
  logic [2*N-1:0] den_c;

  always_comb begin
    ar_x   = {{N{a_re[N-1]}}, a_re};
    ai_x   = {{N{a_im[N-1]}}, a_im};
    br_x   = {{N{b_re[N-1]}}, b_re};
    bi_x   = {{N{b_im[N-1]}}, b_im};
    p_rr   = ar_x * br_x;
    p_ii   = ai_x * bi_x;
    p_ir   = ai_x * br_x;
    p_ri   = ar_x * bi_x;
    p_bb_r = br_x * br_x;
    p_bb_i = bi_x * bi_x;
    num_re = {p_rr[2*N-1], p_rr} + {p_ii[2*N-1], p_ii};
    num_im = {p_ir[2*N-1], p_ir} - {p_ri[2*N-1], p_ri};
    // |num| never exceeds 2^(2N-1), so negating the low 2N bits is exact.
    abs_re = num_re[2*N] ? -num_re[2*N-1:0] : num_re[2*N-1:0];
    abs_im = num_im[2*N] ? -num_im[2*N-1:0] : num_im[2*N-1:0];
    den_c  = p_bb_r + p_bb_i;
  end

  // One restoring step per lane; dividend bits leave dq at the top, quotient bits enter at the bottom.
  logic [2*N:0]   rs_re, rs_im;
  logic           ge_re, ge_im;
  logic [2*N-1:0] diff_re, diff_im;
  logic [2*N-1:0] rem_re_nx, rem_im_nx;
  logic [W-1:0]   dq_re_nx, dq_im_nx;

  always_comb begin
    rs_re     = {rem_re, dq_re[W-1]};
    rs_im     = {rem_im, dq_im[W-1]};
    ge_re     = rs_re >= {1'b0, den};
    ge_im     = rs_im >= {1'b0, den};
    diff_re   = rs_re[2*N-1:0] - den;
    diff_im   = rs_im[2*N-1:0] - den;
    rem_re_nx = ge_re ? diff_re : rs_re[2*N-1:0];
    rem_im_nx = ge_im ? diff_im : rs_im[2*N-1:0];
    dq_re_nx  = {dq_re[W-2:0], ge_re};
    dq_im_nx  = {dq_im[W-2:0], ge_im};
  end

  function automatic logic [N-1:0] saturate(input logic [W-1:0] mag, input logic neg);
    logic [N-1:0] m;
    m = mag[N-1:0];
    if (!neg)
      return (mag > POS_LIM) ? {1'b0, {(N-1){1'b1}}} : m;
    else if (mag > NEG_LIM)
      return {1'b1, {(N-1){1'b0}}};
    else
      return -m;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      z_real      <= '0;
      z_imag      <= '0;
      a_re        <= '0;
      a_im        <= '0;
      b_re        <= '0;
      b_im        <= '0;
      den         <= '0;
      neg_re      <= 1'b0;
      neg_im      <= 1'b0;
      rem_re      <= '0;
      rem_im      <= '0;
      dq_re       <= '0;
      dq_im       <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_re  <= x1_real;
            a_im  <= x1_imag;
            b_re  <= x2_real;
            b_im  <= x2_imag;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          if (den_c == '0) begin
            z_real      <= '0;
            z_imag      <= '0;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            state       <= S_IDLE;
          end else begin
            den    <= den_c;
            neg_re <= num_re[2*N];
            neg_im <= num_im[2*N];
            dq_re  <= {abs_re, {Q{1'b0}}};
            dq_im  <= {abs_im, {Q{1'b0}}};
            rem_re <= '0;
            rem_im <= '0;
            cnt    <= '0;
            state  <= S_DIV;
          end
        end
        S_DIV: begin
          rem_re <= rem_re_nx;
          rem_im <= rem_im_nx;
          dq_re  <= dq_re_nx;
          dq_im  <= dq_im_nx;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            z_real      <= saturate(dq_re_nx, neg_re);
            z_imag      <= saturate(dq_im_nx, neg_im);
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_MUL) || (state == S_DIV);

endmodule

// File: tb/tb_complex_divider.sv
// Scoreboard bench for complex_divider: stimulus pushes expected results, a negedge monitor pops on done.
module tb_complex_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] x1_real = '0, x1_imag = '0, x2_real = '0, x2_imag = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] z_real, z_imag;

  complex_divider dut (
    .clk(clk), .rst(rst), .start(start),
    .x1_real(x1_real), .x1_imag(x1_imag), .x2_real(x2_real), .x2_imag(x2_imag),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .z_real(z_real), .z_imag(z_imag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] zr;
    logic [15:0] zi;
    logic        dbz;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_z_real"}, 32'(z_real), 32'(e.zr));
        check({e.name, "_z_imag"}, 32'(z_imag), 32'(e.zi));
        check({e.name, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
        check({e.name, "_latency"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  // Called at a negedge; start is sampled on the following posedge.
  task automatic issue(input string name, input logic [15:0] a, b, c, d,
                       input logic [15:0] ezr, ezi, input logic edbz, input bit expect_done);
    exp_t e;
    x1_real = a; x1_imag = b; x2_real = c; x2_imag = d;
    start = 1'b1;
    if (expect_done) begin
      e.zr = ezr; e.zi = ezi; e.dbz = edbz; e.name = name;
      e.due = cyc + (edbz ? 2 : 42);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs to prove they were captured.
    x1_real = 16'h1234; x1_imag = 16'hBEEF; x2_real = 16'h0000; x2_imag = 16'h0000;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_z_real", 32'(z_real), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue("basic", 16'h0200, 16'h0200, 16'h0100, 16'h0100, 16'h0200, 16'h0000, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("busy_mid_op", 32'(busy), 32'd1);
    drain("basic");
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);

    issue("rotation", 16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'hFF00, 1'b0, 1'b1);
    drain("rotation");
    issue("trunc_pos", 16'h0100, 16'h0000, 16'h0300, 16'h0000, 16'h0055, 16'h0000, 1'b0, 1'b1);
    drain("trunc_pos");
    issue("trunc_neg", 16'hFF00, 16'h0000, 16'h0300, 16'h0000, 16'hFFAB, 16'h0000, 1'b0, 1'b1);
    drain("trunc_neg");
    issue("saturate", 16'h7FFF, 16'h8000, 16'h0001, 16'h0000, 16'h7FFF, 16'h8000, 1'b0, 1'b1);
    drain("saturate");
    issue("div_zero", 16'h0300, 16'h0400, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1);
    drain("div_zero");
    issue("dbz_clear", 16'h0200, 16'h0200, 16'h0100, 16'h0100, 16'h0200, 16'h0000, 1'b0, 1'b1);
    drain("dbz_clear");

    // start pulsed during DIV with a zero divisor must be ignored.
    issue("ignore_start", 16'h0100, 16'h0000, 16'h0300, 16'h0000, 16'h0055, 16'h0000, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    x2_real = 16'h0000; x2_imag = 16'h0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("ignore_start");
    repeat (50) @(negedge clk);

    // Back-to-back: second start in the done cycle of the first.
    issue("b2b_first", 16'h0200, 16'h0200, 16'h0100, 16'h0100, 16'h0200, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    issue("b2b_second", 16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'hFF00, 1'b0, 1'b1);
    drain("b2b");

    // Reset mid-operation aborts with no done.
    issue("abort", 16'h0200, 16'h0200, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_z_imag", 32'(z_imag), 32'd0);
    check("abort_z_real", 32'(z_real), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("abort_idle_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
